// File: rtl/defect_mask_analyzer_if.sv
// Stream-in / result-out bundle for defect_mask_analyzer.
// master: pixel source and result consumer; slave: the analyzer.
interface defect_mask_analyzer_if #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int DATA_WIDTH = 8
);
  localparam int CW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);
  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_pixel;
  logic                  res_valid;
  logic                  res_ready;
  logic [CW-1:0]         defect_count;
  logic                  defect_flag;
  logic [XW-1:0]         x_min;
  logic [XW-1:0]         x_max;
  logic [YW-1:0]         y_min;
  logic [YW-1:0]         y_max;

  modport master (
    output s_valid, s_pixel, res_ready,
    input  s_ready, res_valid, defect_count, defect_flag,
           x_min, x_max, y_min, y_max
  );

  modport slave (
    input  s_valid, s_pixel, res_ready,
    output s_ready, res_valid, defect_count, defect_flag,
           x_min, x_max, y_min, y_max
  );
endinterface

// File: rtl/defect_mask_analyzer.sv
// Defect mask analyzer: counts nonzero pixels of a raster-order mask frame,
// flags the frame against a threshold and (optionally) tracks the defect
// bounding box. Bounding-box tracking is built in only when the macro
// DEFECT_MASK_BBOX_EN is defined; otherwise box outputs are tied to 0.
//
// state  | meaning
// ACCUM  | accepting pixels, running count/box updated per transfer
// REPORT | frame result held on outputs until res_valid && res_ready
module defect_mask_analyzer #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int DATA_WIDTH = 8,
  localparam int CW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1),
  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1,
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CW-1:0]           min_defect_count,
  defect_mask_analyzer_if.slave   bus
);

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic          res_valid_q, res_valid_d;

  logic xfer;
  logic defect;
  logic last_x;
  logic last_y;
  logic accept;

  assign xfer   = bus.s_valid && (state_q == ACCUM);
  assign defect = |bus.s_pixel;
  assign last_x = (x_q == XW'(IMG_WIDTH - 1));
  assign last_y = (y_q == YW'(IMG_HEIGHT - 1));
  assign accept = (state_q == REPORT) && bus.res_ready;

  // Next-state, raster position, running count and threshold flag.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    flag_d      = flag_q;
    res_valid_d = res_valid_q;
    case (state_q)
      ACCUM: begin
        if (xfer) begin
          if (defect) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (last_x) begin
            x_d = '0;
            y_d = last_y ? '0 : y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          if (last_x && last_y) begin
            // Threshold uses the count including the frame's final pixel.
            state_d     = REPORT;
            res_valid_d = 1'b1;
            flag_d      = (cnt_d >= min_defect_count);
          end
        end
      end
      REPORT: begin
        if (bus.res_ready) begin
          state_d     = ACCUM;
          res_valid_d = 1'b0;
          cnt_d       = '0;
          flag_d      = 1'b0;
          x_d         = '0;
          y_d         = '0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State, position, count and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.s_ready      = (state_q == ACCUM);
  assign bus.res_valid    = res_valid_q;
  assign bus.defect_count = cnt_q;
  assign bus.defect_flag  = flag_q;

`ifdef DEFECT_MASK_BBOX_EN
  logic          have_q, have_d;
  logic [XW-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
  logic [YW-1:0] y_min_q, y_min_d, y_max_q, y_max_d;

  // Bounding box: first defect seeds all four edges, later ones widen them.
  always_comb begin
    have_d  = have_q;
    x_min_d = x_min_q;
    x_max_d = x_max_q;
    y_min_d = y_min_q;
    y_max_d = y_max_q;
    if (xfer && defect) begin
      have_d = 1'b1;
      if (!have_q) begin
        x_min_d = x_q;
        x_max_d = x_q;
        y_min_d = y_q;
        y_max_d = y_q;
      end else begin
        if (x_q < x_min_q) x_min_d = x_q;
        if (x_q > x_max_q) x_max_d = x_q;
        if (y_q < y_min_q) y_min_d = y_q;
        if (y_q > y_max_q) y_max_d = y_q;
      end
    end
    if (accept) begin
      have_d  = 1'b0;
      x_min_d = '0;
      x_max_d = '0;
      y_min_d = '0;
      y_max_d = '0;
    end
  end

  // Bounding-box registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_q  <= 1'b0;
      x_min_q <= '0;
      x_max_q <= '0;
      y_min_q <= '0;
      y_max_q <= '0;
    end else begin
      have_q  <= have_d;
      x_min_q <= x_min_d;
      x_max_q <= x_max_d;
      y_min_q <= y_min_d;
      y_max_q <= y_max_d;
    end
  end

  assign bus.x_min = x_min_q;
  assign bus.x_max = x_max_q;
  assign bus.y_min = y_min_q;
  assign bus.y_max = y_max_q;
`else
  assign bus.x_min = '0;
  assign bus.x_max = '0;
  assign bus.y_min = '0;
  assign bus.y_max = '0;
`endif

endmodule

// File: doc/defect_mask_analyzer.md
DEFECT_MASK_ANALYZER -- requirements
Module: defect_mask_analyzer

Interface
REQ-001 Parameter IMG_WIDTH, default 64, pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 64, lines per frame; frame size is IMG_WIDTH*IMG_HEIGHT (default 4096).
REQ-003 Parameter DATA_WIDTH, default 8, bits per mask pixel.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 s_valid  input  1  mask pixel valid.
REQ-007 s_ready  output  1  block accepts pixel.
REQ-008 s_pixel  input  DATA_WIDTH  thresholded pixel, raster order; any nonzero value counts as a defect pixel.
REQ-009 min_defect_count  input  CW  defect-pixel threshold, CW = $clog2(IMG_WIDTH*IMG_HEIGHT+1).
REQ-010 res_valid  output  1  frame result valid.
REQ-011 res_ready  input  1  result consumer ready.
REQ-012 defect_count  output  CW  defect pixels in frame.
REQ-013 defect_flag  output  1  high when defect_count >= min_defect_count.
REQ-014 x_min, x_max  output  XW each  bounding-box columns, XW = $clog2(IMG_WIDTH).
REQ-015 y_min, y_max  output  YW each  bounding-box rows, YW = $clog2(IMG_HEIGHT).

Function
REQ-016 Two-state FSM, ACCUM and REPORT; reset enters ACCUM.
REQ-017 ACCUM: s_ready=1; a transfer is a cycle with s_valid&&s_ready.
REQ-018 Each transfer advances column counter x; x wraps from IMG_WIDTH-1 to 0 and increments row y.
REQ-019 Nonzero pixel on transfer increments the running count by 1; count never wraps (max frame size fits CW).
REQ-020 Transfer at x=IMG_WIDTH-1, y=IMG_HEIGHT-1 ends frame: next cycle FSM in REPORT, res_valid=1, outputs hold the complete-frame result including that last pixel; latency one cycle.
REQ-021 REPORT: s_ready=0; all result outputs stable until res_valid&&res_ready.
REQ-022 On res_valid&&res_ready: return to ACCUM next cycle, x=y=0, running count and box cleared, res_valid=0.
REQ-023 defect_flag compared against min_defect_count sampled at the frame-ending transfer; min_defect_count=0 yields defect_flag=1 even with zero defects.
REQ-024 Box: first defect pixel of a frame loads x_min=x_max=x, y_min=y_max=y; later defects update min/max per coordinate.
REQ-025 Frame with zero defects reports count 0, flag per REQ-023, all box outputs 0.
REQ-026 Idle cycles (s_valid=0) in ACCUM alter no state.
REQ-027 Outputs other than s_ready are registered; s_ready is decoded from FSM state only.

Reset
REQ-028 rst_n low asynchronously: FSM=ACCUM, x=y=0, running count and box cleared, res_valid=0, defect_count=0, defect_flag=0, all box outputs 0; s_ready=1 from the first cycle after release.
REQ-029 Reset mid-frame or mid-REPORT discards the partial frame/pending result; the next transfer is pixel (0,0).

Configuration
REQ-030 Macro DEFECT_MASK_BBOX_EN defined: bounding-box tracking per REQ-024/025 built in.
REQ-031 Macro undefined: no box registers; x_min, x_max, y_min, y_max tied to 0; count, flag, handshake unchanged.

Verification
REQ-032 Reset, frame of 4096 zero pixels, min=1, res_ready=1 -> res_valid one cycle after last transfer, count=0, flag=0, box all 0.
REQ-033 Single 0xFF at (5,7), min=1 -> count=1, flag=1, x_min=x_max=5, y_min=y_max=7.
REQ-034 0xFF at (10,2), (3,40), (60,63), min=4 -> count=3, flag=0, x 3..60, y 2..63 (box 0 when DEFECT_MASK_BBOX_EN undefined).
REQ-035 Hold res_ready=0 for 20 cycles in REPORT with s_valid=1 -> s_ready=0, outputs stable, no pixel consumed; accept, then next frame starts at (0,0).
REQ-036 Random s_valid gaps, all pixels 0xFF -> count=4096, flag=1, box 0..63 both axes.
REQ-037 Assert rst_n low after 1000 pixels with 50 defects, then clean frame with one defect at (0,0) -> count=1, box all 0, flag per min.
